// File: rtl/cram_wr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cram_wr_arbiter_pkg
//   Shared definitions for the CRAM write-port arbiter:
//   - default CRAM geometry (address / data width)
//   - fill sequencer state encoding
//   - requester (grant) identifiers and the fixed-priority pick function
// -----------------------------------------------------------------------------
package cram_wr_arbiter_pkg;

  localparam int unsigned CRAM_AW = 8;   // 256 palette entries
  localparam int unsigned CRAM_DW = 16;  // one palette word

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2,
    GNT_FILL = 2'd3
  } gnt_e;

  // Fixed priority CPU > DMA > FILL. Inputs are already qualified by any
  // blank gating / ack throttling, so this is a pure priority pick.
  function automatic gnt_e arbitrate(input logic cpu_ok,
                                     input logic dma_ok,
                                     input logic fill_ok);
    if (cpu_ok)       return GNT_CPU;
    else if (dma_ok)  return GNT_DMA;
    else if (fill_ok) return GNT_FILL;
    else              return GNT_NONE;
  endfunction

endpackage

// File: rtl/cram_wr_arbiter_fill_seq.sv
// -----------------------------------------------------------------------------
// cram_wr_arbiter_fill_seq
//   Fill engine: writes one captured value to every CRAM entry, one entry per
//   granted cycle, in ascending address order.
// Ports
//   clk, res     video clock, synchronous active-high reset
//   fill_start   one-cycle start pulse (ignored while busy)
//   fill_data    fill value, captured on an accepted start
//   fill_gnt     arbiter grant for the entry at fill_addr (this cycle)
//   fill_req     a fill write is wanted this cycle
//   fill_addr    entry to be written when granted
//   fill_word    captured fill value
//   fill_busy    registered: fill in progress
//   fill_done    registered: pulses alongside the CRAM write of the last entry
// -----------------------------------------------------------------------------
module cram_wr_arbiter_fill_seq
  import cram_wr_arbiter_pkg::*;
#(
  parameter int unsigned AW = CRAM_AW,
  parameter int unsigned DW = CRAM_DW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_data,
  input  logic          fill_gnt,
  output logic          fill_req,
  output logic [AW-1:0] fill_addr,
  output logic [DW-1:0] fill_word,
  output logic          fill_busy,
  output logic          fill_done
);

  fill_state_e   state_q;
  logic [AW-1:0] cnt_q;
  logic [DW-1:0] val_q;
  logic          busy_q;
  logic          done_q;

  // NOTE: every sequential register here is assigned with <= only, so all
  // branches read the pre-edge values and the evaluation order does not matter.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fill_start) begin
            val_q   <= fill_data;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          // Losing arbitration simply leaves the counter where it is, so no
          // entry is skipped or repeated.
          if (fill_gnt) begin
            cnt_q <= cnt_q + 1'b1;  // wraps to 0 after the last entry
            if (cnt_q == '1) begin
              // done/busy are registered, so they change in the same cycle
              // the last entry reaches the CRAM port.
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fill_req  = (state_q == ST_FILL);
  assign fill_addr = cnt_q;
  assign fill_word = val_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;

endmodule

// File: rtl/cram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// cram_wr_arbiter
//   Owns the single CRAM write port of the palette lookup and shares it
//   between Z80 byte writes (assembled to words), DMA word writes (req/ack)
//   and the internal fill engine. Priority CPU > DMA > FILL. All CRAM-facing
//   outputs are registered: a grant in cycle N appears on the port in N+1.
// Ports
//   clk, res           video clock, synchronous active-high reset
//   blank              video blank; gates DMA/FILL when DMA_BLANK_ONLY=1
//   cpu_wr/addr/data   Z80 byte write strobe, byte address, byte
//   dma_req/addr/data  DMA word request (held until dma_ack)
//   dma_ack            pulses in the cycle the DMA word is on the CRAM port
//   fill_start/data    start a full-table fill with the given value
//   fill_busy/done     fill in progress / last-entry pulse
//   cram_we/addr/data  CRAM write port
// -----------------------------------------------------------------------------
module cram_wr_arbiter
  import cram_wr_arbiter_pkg::*;
#(
  parameter int unsigned AW             = CRAM_AW,
  parameter int unsigned DW             = CRAM_DW,
  parameter bit          DMA_BLANK_ONLY = 1'b0
) (
  input  logic          clk,
  input  logic          res,
  input  logic          blank,
  input  logic          cpu_wr,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_data,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_data,
  output logic          dma_ack,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_data,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          cram_we,
  output logic [AW-1:0] cram_addr,
  output logic [DW-1:0] cram_data
);

  logic          cpu_hi;
  logic          bus_gate;
  logic          dma_ok;
  logic          fill_ok;
  logic          fill_req;
  logic          fill_gnt;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_word;
  gnt_e          gnt;

  logic [DW-9:0] lo_latch_q, lo_latch_d;
  logic          cram_we_q,  cram_we_d;
  logic [AW-1:0] cram_addr_q, cram_addr_d;
  logic [DW-1:0] cram_data_q, cram_data_d;
  logic          dma_ack_q,  dma_ack_d;

  // Only the high-byte strobe produces a CRAM write; the low byte just
  // lands in lo_latch.
  assign cpu_hi   = cpu_wr & cpu_addr[0];
  assign bus_gate = ~DMA_BLANK_ONLY | blank;
  // Refusing a grant while dma_ack is high gives the DMA source a cycle to
  // drop or advance its request, hence one word per two clocks at most.
  assign dma_ok   = dma_req & ~dma_ack_q & bus_gate;
  assign fill_ok  = fill_req & bus_gate;
  assign gnt      = arbitrate(cpu_hi, dma_ok, fill_ok);
  assign fill_gnt = (gnt == GNT_FILL);

  cram_wr_arbiter_fill_seq #(
    .AW (AW),
    .DW (DW)
  ) u_fill_seq (
    .clk        (clk),
    .res        (res),
    .fill_start (fill_start),
    .fill_data  (fill_data),
    .fill_gnt   (fill_gnt),
    .fill_req   (fill_req),
    .fill_addr  (fill_addr),
    .fill_word  (fill_word),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and no latch is inferred.
  always_comb begin
    lo_latch_d  = lo_latch_q;
    cram_we_d   = 1'b0;
    cram_addr_d = cram_addr_q;   // address/data hold when nothing is granted
    cram_data_d = cram_data_q;
    dma_ack_d   = 1'b0;

    if (cpu_wr && !cpu_addr[0]) begin
      lo_latch_d = cpu_data;
    end

    case (gnt)
      GNT_CPU: begin
        cram_we_d   = 1'b1;
        cram_addr_d = cpu_addr[AW:1];
        cram_data_d = {cpu_data, lo_latch_q};
      end
      GNT_DMA: begin
        cram_we_d   = 1'b1;
        cram_addr_d = dma_addr;
        cram_data_d = dma_data;
        dma_ack_d   = 1'b1;
      end
      GNT_FILL: begin
        cram_we_d   = 1'b1;
        cram_addr_d = fill_addr;
        cram_data_d = fill_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      lo_latch_q  <= '0;
      cram_we_q   <= 1'b0;
      cram_addr_q <= '0;
      cram_data_q <= '0;
      dma_ack_q   <= 1'b0;
    end else begin
      lo_latch_q  <= lo_latch_d;
      cram_we_q   <= cram_we_d;
      cram_addr_q <= cram_addr_d;
      cram_data_q <= cram_data_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign cram_we   = cram_we_q;
  assign cram_addr = cram_addr_q;
  assign cram_data = cram_data_q;
  assign dma_ack   = dma_ack_q;

endmodule

// File: tb/tb_cram_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cram_wr_arbiter
//   Directed bench for cram_wr_arbiter. Two instances share all inputs:
//   dut_a (DMA_BLANK_ONLY=0) and dut_b (DMA_BLANK_ONLY=1). blank is held high
//   except in the blank-gating scenario, so both behave alike elsewhere.
//   Inputs change 1 ns after a rising edge; outputs are checked at that same
//   point, i.e. they show the result of the edge that just occurred.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cram_wr_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic        blank;
  logic        cpu_wr;
  logic [8:0]  cpu_addr;
  logic [7:0]  cpu_data;
  logic        dma_req;
  logic [7:0]  dma_addr;
  logic [15:0] dma_data;
  logic        fill_start;
  logic [15:0] fill_data;

  logic        a_ack, a_busy, a_done, a_we;
  logic [7:0]  a_addr;
  logic [15:0] a_data;
  logic        b_ack, b_busy, b_done, b_we;
  logic [7:0]  b_addr;
  logic [15:0] b_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  cram_wr_arbiter #(.DMA_BLANK_ONLY(1'b0)) dut_a (
    .clk(clk), .res(res), .blank(blank),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(a_ack),
    .fill_start(fill_start), .fill_data(fill_data),
    .fill_busy(a_busy), .fill_done(a_done),
    .cram_we(a_we), .cram_addr(a_addr), .cram_data(a_data)
  );

  cram_wr_arbiter #(.DMA_BLANK_ONLY(1'b1)) dut_b (
    .clk(clk), .res(res), .blank(blank),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(b_ack),
    .fill_start(fill_start), .fill_data(fill_data),
    .fill_busy(b_busy), .fill_done(b_done),
    .cram_we(b_we), .cram_addr(b_addr), .cram_data(b_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write_a(input string tag, input logic [7:0] addr, input logic [15:0] data);
    check({tag, "_we"},   32'(a_we),   32'd1);
    check({tag, "_addr"}, 32'(a_addr), 32'(addr));
    check({tag, "_data"}, 32'(a_data), 32'(data));
  endtask

  initial begin
    res = 1'b1; blank = 1'b1;
    cpu_wr = 1'b0; cpu_addr = '0; cpu_data = '0;
    dma_req = 1'b0; dma_addr = '0; dma_data = '0;
    fill_start = 1'b0; fill_data = '0;

    // ---------------- reset state ----------------
    step(); step();
    check("rst_we",   32'(a_we),   32'd0);
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_data", 32'(a_data), 32'd0);
    check("rst_ack",  32'(a_ack),  32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    res = 1'b0;

    // ---------------- CPU byte pair ----------------
    cpu_wr = 1'b1; cpu_addr = 9'h010; cpu_data = 8'h34;
    step();
    check("cpu_lo_no_we", 32'(a_we), 32'd0);
    cpu_addr = 9'h011; cpu_data = 8'h12;
    step();
    check_write_a("cpu_hi", 8'h08, 16'h1234);
    cpu_wr = 1'b0;
    step();
    check("cpu_idle_we",   32'(a_we),   32'd0);
    check("cpu_hold_addr", 32'(a_addr), 32'h08);
    check("cpu_hold_data", 32'(a_data), 32'h1234);
    // lo_latch survives the high-byte write
    cpu_wr = 1'b1; cpu_addr = 9'h013; cpu_data = 8'h56;
    step();
    check_write_a("cpu_hi2", 8'h09, 16'h5634);
    cpu_wr = 1'b0;

    // ---------------- DMA held for 4 cycles ----------------
    dma_req = 1'b1; dma_addr = 8'h40; dma_data = 16'hABCD;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("dma_ack_%0d", k), 32'(a_ack), ((k % 2) == 0) ? 32'd1 : 32'd0);
      check($sformatf("dma_we_%0d", k),  32'(a_we),  ((k % 2) == 0) ? 32'd1 : 32'd0);
      if ((k % 2) == 0) begin
        check($sformatf("dma_addr_%0d", k), 32'(a_addr), 32'h40);
        check($sformatf("dma_data_%0d", k), 32'(a_data), 32'hABCD);
      end
    end
    dma_req = 1'b0;
    step();
    check("dma_after_we",  32'(a_we),  32'd0);
    check("dma_after_ack", 32'(a_ack), 32'd0);

    // ---------------- uncontended fill ----------------
    fill_start = 1'b1; fill_data = 16'h7FFF;
    step();
    check("fill_busy_rise", 32'(a_busy), 32'd1);
    check("fill_first_we",  32'(a_we),   32'd0);
    fill_start = 1'b0; fill_data = 16'h0000;   // value must already be captured
    busy_cnt = 1;
    for (int i = 0; i < 256; i++) begin
      step();
      check_write_a($sformatf("fill_%0d", i), 8'(i), 16'h7FFF);
      check($sformatf("fill_done_%0d", i), 32'(a_done), (i == 255) ? 32'd1 : 32'd0);
      if (a_busy) busy_cnt++;
    end
    check("fill_busy_cycles", 32'(busy_cnt), 32'd256);
    step();
    check("fill_end_we",   32'(a_we),   32'd0);
    check("fill_end_done", 32'(a_done), 32'd0);
    check("fill_end_busy", 32'(a_busy), 32'd0);

    // ---------------- fill contended by CPU and DMA at 0x20 ----------------
    fill_start = 1'b1; fill_data = 16'h1111;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      check_write_a($sformatf("cf_%0d", i), 8'(i), 16'h1111);
    end
    cpu_wr = 1'b1; cpu_addr = 9'h0A1; cpu_data = 8'h99;
    dma_req = 1'b1; dma_addr = 8'h41; dma_data = 16'h5555;
    step();
    check_write_a("cf_cpu", 8'h50, 16'h9934);
    check("cf_cpu_ack", 32'(a_ack), 32'd0);
    cpu_wr = 1'b0;
    step();
    check_write_a("cf_dma", 8'h41, 16'h5555);
    check("cf_dma_ack", 32'(a_ack), 32'd1);
    dma_req = 1'b0;
    for (int i = 32; i < 256; i++) begin
      // a start pulse mid-fill must be ignored, value not re-sampled
      fill_start = (i == 48);
      fill_data  = (i == 48) ? 16'hDEAD : 16'h0000;
      step();
      check_write_a($sformatf("cf_%0d", i), 8'(i), 16'h1111);
      check($sformatf("cf_done_%0d", i), 32'(a_done), (i == 255) ? 32'd1 : 32'd0);
    end
    fill_start = 1'b0;
    step();
    check("cf_end_we",   32'(a_we),   32'd0);
    check("cf_end_busy", 32'(a_busy), 32'd0);

    // ---------------- blank gating (dut_b) ----------------
    blank = 1'b0;
    dma_req = 1'b1; dma_addr = 8'h22; dma_data = 16'hBEEF;
    cpu_wr = 1'b1; cpu_addr = 9'h0C1; cpu_data = 8'h77;
    step();
    check("bg_cpu_we",   32'(b_we),   32'd1);
    check("bg_cpu_addr", 32'(b_addr), 32'h60);
    check("bg_cpu_data", 32'(b_data), 32'h7734);
    check("bg_cpu_ack",  32'(b_ack),  32'd0);
    cpu_wr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("bg_wait_we_%0d", k),  32'(b_we),  32'd0);
      check($sformatf("bg_wait_ack_%0d", k), 32'(b_ack), 32'd0);
    end
    blank = 1'b1;
    step();
    check("bg_dma_ack",  32'(b_ack),  32'd1);
    check("bg_dma_we",   32'(b_we),   32'd1);
    check("bg_dma_addr", 32'(b_addr), 32'h22);
    check("bg_dma_data", 32'(b_data), 32'hBEEF);
    dma_req = 1'b0;
    step();
    check("bg_after_ack", 32'(b_ack), 32'd0);

    // ---------------- reset during fill at 0x80 ----------------
    fill_start = 1'b1; fill_data = 16'h3333;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      step();
      check($sformatf("rf_addr_%0d", i), 32'(a_addr), 32'(i));
    end
    res = 1'b1;
    step();
    check("rf_we",   32'(a_we),   32'd0);
    check("rf_busy", 32'(a_busy), 32'd0);
    check("rf_done", 32'(a_done), 32'd0);
    check("rf_b_busy", 32'(b_busy), 32'd0);
    res = 1'b0;
    step();
    check("rf_idle_we",   32'(a_we),   32'd0);
    check("rf_idle_busy", 32'(a_busy), 32'd0);
    check("rf_idle_done", 32'(a_done), 32'd0);
    fill_start = 1'b1; fill_data = 16'h2222;
    step();
    check("rf_restart_busy", 32'(a_busy), 32'd1);
    fill_start = 1'b0;
    step();
    check_write_a("rf_restart", 8'h00, 16'h2222);
    step();
    check_write_a("rf_restart1", 8'h01, 16'h2222);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
